// File: rtl/countdown_sequencer.sv
// countdown_sequencer: drives load/decrement of a two-digit ASCII down-counter with pause, abort and expiry
module countdown_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int TICK_W   = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    input  logic [15:0] cnt_in,
    output logic        cnt_load,
    output logic [15:0] cnt_value,
    output logic        cnt_dec,
    output logic        busy,
    output logic        expired,
    output logic        alarm,
    output logic        error,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        PAUSED  = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    localparam logic [15:0]       UN   = 16'h554E;
    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   presc_q, presc_d;
    logic [15:0]         cnt_value_q, cnt_value_d;
    logic                cnt_load_q, cnt_load_d;
    logic                cnt_dec_q, cnt_dec_d;
    logic                expired_q, expired_d;
    logic                error_q, error_d;
    logic                value_ok;
    logic                is_un;

    assign value_ok = value[15:8] >= 8'h30 && value[15:8] <= 8'h39 &&
                      value[7:0]  >= 8'h30 && value[7:0]  <= 8'h39 &&
                      value != 16'h3030;
    assign is_un    = cnt_in == UN;

    // next-state, prescaler and registered-output computation
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        cnt_value_d = cnt_value_q;
        error_d     = error_q;
        cnt_dec_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    error_d     = !value_ok;
                    cnt_value_d = value_ok ? value : cnt_value_q;
                    state_d     = value_ok ? LOAD : IDLE;
                end
            end
            LOAD: begin
                presc_d = '0;
                state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (is_un) begin
                    state_d = EXPIRED;
                end else if (pause) begin
                    state_d = PAUSED;
                end else begin
                    cnt_dec_d = presc_q == LAST;
                    presc_d   = (presc_q == LAST) ? '0 : presc_q + TICK_W'(1);
                end
            end
            PAUSED: begin
                if (abort) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            EXPIRED: begin
                if (abort) begin
                    state_d = IDLE;
                    presc_d = '0;
                end else if (start) begin
                    error_d     = !value_ok;
                    cnt_value_d = value_ok ? value : cnt_value_q;
                    state_d     = value_ok ? LOAD : EXPIRED;
                end
            end
            default: begin
                state_d = IDLE;
                presc_d = '0;
            end
        endcase
        cnt_load_d = state_d == LOAD;
        expired_d  = state_d == EXPIRED && state_q != EXPIRED;
    end

    // state and output registers; reset abandons any countdown without touching the counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            cnt_value_q <= 16'h3030;
            cnt_load_q  <= 1'b0;
            cnt_dec_q   <= 1'b0;
            expired_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_value_q <= cnt_value_d;
            cnt_load_q  <= cnt_load_d;
            cnt_dec_q   <= cnt_dec_d;
            expired_q   <= expired_d;
            error_q     <= error_d;
        end
    end

    assign cnt_load  = cnt_load_q;
    assign cnt_value = cnt_value_q;
    assign cnt_dec   = cnt_dec_q;
    assign expired   = expired_q;
    assign error     = error_q;
    assign busy      = state_q == LOAD || state_q == RUN || state_q == PAUSED;
    assign alarm     = state_q == EXPIRED;
    assign state     = state_q;
endmodule

// File: tb/tb_countdown_sequencer.sv
// tb_countdown_sequencer: directed and random checks against an integer-level model with an attached counter
module tb_countdown_sequencer;
    localparam int TD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] value = 16'h3030;
    logic [15:0] cnt_in;
    logic        cnt_load, cnt_dec, busy, expired, alarm, error;
    logic [15:0] cnt_value;
    logic [2:0]  state;

    int checks = 0;
    int failures = 0;
    int dec_seen = 0;
    int ctr = 0;

    int          m_state = 0;
    int          m_left = 0;
    int          m_ctr = 0;
    logic [15:0] m_val = 16'h3030;
    bit          m_err = 0, m_load = 0, m_dec = 0, m_exp = 0;

    countdown_sequencer #(.TICK_DIV(TD), .TICK_W(32)) dut (
        .clock(clock), .reset(reset), .value(value), .start(start), .pause(pause),
        .abort(abort), .cnt_in(cnt_in), .cnt_load(cnt_load), .cnt_value(cnt_value),
        .cnt_dec(cnt_dec), .busy(busy), .expired(expired), .alarm(alarm),
        .error(error), .state(state)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] to_ascii(input int n);
        logic [7:0] t, u;
        t = 8'h30 + 8'(n / 10);
        u = 8'h30 + 8'(n % 10);
        return (n < 0) ? 16'h554E : {t, u};
    endfunction

    function automatic int from_ascii(input logic [15:0] v);
        return (int'(v[15:8]) - 48) * 10 + (int'(v[7:0]) - 48);
    endfunction

    function automatic bit valid(input logic [15:0] v);
        return v[15:8] >= 8'h30 && v[15:8] <= 8'h39 && v[7:0] >= 8'h30 &&
               v[7:0] <= 8'h39 && v != 16'h3030;
    endfunction

    // the counter the sequencer controls, driven by the DUT's own outputs
    assign cnt_in = to_ascii(ctr);
    always @(posedge clock) begin
        if (cnt_load) ctr <= from_ascii(cnt_value);
        else if (cnt_dec) ctr <= (ctr <= 1) ? -1 : ctr - 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("state", 16'(state), 16'(m_state));
        chk("busy", 16'(busy), 16'(m_state >= 1 && m_state <= 3));
        chk("alarm", 16'(alarm), 16'(m_state == 4));
        chk("cnt_load", 16'(cnt_load), 16'(m_load));
        chk("cnt_dec", 16'(cnt_dec), 16'(m_dec));
        chk("expired", 16'(expired), 16'(m_exp));
        chk("error", 16'(error), 16'(m_err));
        chk("cnt_value", cnt_value, m_val);
    endtask

    task automatic model_reset();
        m_state = 0; m_left = 0; m_val = 16'h3030;
        m_err = 0; m_load = 0; m_dec = 0; m_exp = 0;
    endtask

    // one clock with the given inputs; model predicts post-edge outputs
    task automatic cyc(input bit s, input bit p, input bit a, input logic [15:0] v);
        int nxt, nleft;
        bit ndec, nerr;
        logic [15:0] nval;
        start = s; pause = p; abort = a; value = v;
        nxt = m_state; nleft = m_left; ndec = 0; nerr = m_err; nval = m_val;
        if (m_state == 0) begin
            if (!a && s) begin
                if (valid(v)) begin nval = v; nerr = 0; nxt = 1; end
                else nerr = 1;
            end
        end else if (m_state == 1) begin
            nxt = a ? 0 : 2;
            nleft = TD;
        end else if (m_state == 2) begin
            if (a) nxt = 0;
            else if (m_ctr < 0) nxt = 4;
            else if (p) nxt = 3;
            else begin
                nleft = m_left - 1;
                if (nleft == 0) begin ndec = 1; nleft = TD; end
            end
        end else if (m_state == 3) begin
            if (a) nxt = 0;
            else if (!p) nxt = 2;
        end else begin
            if (a) nxt = 0;
            else if (s) begin
                if (valid(v)) begin nval = v; nerr = 0; nxt = 1; end
                else nerr = 1;
            end
        end
        if (m_load) m_ctr = from_ascii(m_val);
        else if (m_dec) m_ctr = (m_ctr <= 1) ? -1 : m_ctr - 1;
        m_load = nxt == 1;
        m_dec = ndec;
        m_exp = nxt == 4 && m_state != 4;
        m_state = nxt; m_left = nleft; m_err = nerr; m_val = nval;
        @(posedge clock);
        #1;
        if (cnt_dec === 1'b1) dec_seen++;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 16'h3030);
    endtask

    initial begin
        logic [7:0] tn, un;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;
        idle(2);

        dec_seen = 0;
        cyc(1, 0, 0, "03");
        idle(20);
        chk("dec_count_03", 16'(dec_seen), 16'd3);
        chk("expired_state_03", 16'(state), 16'd4);
        cyc(0, 0, 1, 16'h3030);
        idle(2);

        dec_seen = 0;
        cyc(1, 0, 0, "10");
        idle(50);
        chk("dec_count_10", 16'(dec_seen), 16'd10);

        cyc(1, 0, 0, "02");
        idle(15);
        cyc(0, 0, 1, 16'h3030);

        cyc(1, 0, 0, "0A"); idle(2);
        cyc(1, 0, 0, "00"); idle(2);
        cyc(1, 0, 0, "5:"); idle(2);
        cyc(1, 0, 0, "07"); idle(8);
        cyc(0, 0, 1, 16'h3030);

        cyc(1, 0, 0, "05");
        idle($urandom_range(3, 7));
        repeat (10) cyc(0, 1, 0, 16'h3030);
        idle(30);

        cyc(1, 0, 0, "05");
        idle(6);
        cyc(1, 0, 1, "09");
        idle(4);

        cyc(1, 0, 0, "09");
        idle(7);
        reset = 1'b0;
        #2;
        model_reset();
        check_all();
        #1;
        reset = 1'b1;
        dec_seen = 0;
        idle(20);
        chk("dec_after_reset", 16'(dec_seen), 16'd0);

        repeat (500) begin
            tn = 8'h30 + 8'($urandom_range(0, 1));
            un = 8'h30 + 8'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) un = ($urandom_range(0, 1) == 0) ? 8'h3A : 8'h2F;
            cyc($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 3, {tn, un});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Sequences the two-digit ASCII down-counter datapath (load / decrement / "UN" terminal value).
- Validates and latches a start value, pulses the counter's synchronous load, then issues one decrement every TICK_DIV clocks.
- Supports pause, abort and expiry signalling.
- Sits between user-control logic and one counter instance.

Parameters:
- TICK_DIV, 4, clocks between decrement pulses (must be >= 2).
- TICK_W, 32, prescaler width (must hold TICK_DIV-1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- value  in  16  start value; [15:8] tens digit, [7:0] units digit, ASCII.
- start  in  1  request countdown from value (sampled each edge).
- pause  in  1  level: hold countdown while high.
- abort  in  1  cancel countdown, return to IDLE.
- cnt_in  in  16  counter's current cnt.
- cnt_load  out  1  drives the counter's synchronous load (its reset input).
- cnt_value  out  16  drives the counter's ascii_in.
- cnt_dec  out  1  drives the counter's decrement.
- busy  out  1  high in LOAD, RUN, PAUSED.
- expired  out  1  one-cycle pulse on entry to EXPIRED.
- alarm  out  1  high while in EXPIRED.
- error  out  1  sticky: last start carried an invalid value.
- state  out  3  IDLE=0, LOAD=1, RUN=2, PAUSED=3, EXPIRED=4.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, prescaler=0, cnt_value="00" (16'h3030).
  - cnt_load, cnt_dec, expired, alarm and error all 0.
  - Reset mid-countdown aborts immediately. The counter is not reloaded.
- All outputs are registered.
- Event priority per cycle: abort > start > pause > tick.
- Valid value:
  - Both bytes are in "0".."9" (8'h30..8'h39) and value != "00".
  - start with an invalid value: error=1, state unchanged, cnt_value unchanged.
  - start with a valid value: error=0.
- IDLE:
  - start with a valid value latches cnt_value, then goes to LOAD.
  - pause is ignored.
- LOAD:
  - cnt_load=1 for exactly this one cycle; prescaler is cleared to 0.
  - Next state is RUN unconditionally, unless abort is high, which goes to IDLE.
- RUN:
  - Each cycle, the prescaler increments.
  - When the prescaler equals TICK_DIV-1, it wraps to 0 and cnt_dec=1 for one cycle.
  - The first decrement arrives TICK_DIV cycles after entering RUN, then every TICK_DIV cycles.
  - cnt_dec is suppressed whenever cnt_in=="UN".
  - cnt_in=="UN" moves to EXPIRED on the next edge. This takes priority over pause and tick, but not over abort.
  - pause=1 goes to PAUSED; the prescaler value is frozen.
  - start is ignored; error is not updated.
- PAUSED:
  - Prescaler frozen, no cnt_dec.
  - pause=0 returns to RUN and the prescaler resumes from its frozen value.
  - start is ignored.
- EXPIRED:
  - expired=1 on the first cycle only; alarm=1 throughout.
  - start with a valid value goes to LOAD (restart).
  - start with an invalid value sets error and stays in EXPIRED.
- abort in LOAD, RUN, PAUSED or EXPIRED:
  - Next state IDLE; cnt_dec=0; prescaler=0.
  - cnt_value is retained.
- busy and alarm are decoded from the registered state, so they are valid the cycle after the transition.
- cnt_dec and cnt_load are never high in the same cycle.

Test Plan:
- Reset, then start with value="03", TICK_DIV=4:
  - cnt_load is high 1 cycle after the start edge.
  - Three cnt_dec pulses, 4 cycles apart.
  - Counter goes "03"→"02"→"01"→"UN".
  - The cycle after cnt_in=="UN": state=EXPIRED, expired is a 1-cycle pulse, alarm=1.
- start with value="10":
  - After the first cnt_dec, cnt_in="09" (tens borrow).
  - A total of 10 cnt_dec pulses occur before EXPIRED.
- start with "0A", then "00", then "5:":
  - Each sets error=1, state stays IDLE, no cnt_load.
  - A following start with "07" clears error and enters LOAD.
- During RUN with "05":
  - Raise pause for 10 cycles mid-prescale: no cnt_dec, state=PAUSED.
  - On release, the next cnt_dec arrives after the remaining prescale cycles, not a full TICK_DIV.
- Same cycle start+abort in RUN: state→IDLE, no reload.
- Abort in EXPIRED: alarm drops.
- start "02" while in EXPIRED: restart, cnt_load pulses.
- Assert reset low for part of a cycle mid-RUN:
  - All outputs drop asynchronously, state=IDLE.
  - After release, no cnt_dec occurs until a new start.
